control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; opcode values and state encodings come from the shared package.
REQ-002 Clock  in  1  single clock; all state changes on the rising edge.
REQ-003 clear  in  1  reset, asynchronous and active-low.
REQ-004 IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-005 Stop  in  1  halt request, sampled at instruction boundaries.
REQ-006 Run  out  1  high in every state except RST and HALT.
REQ-007 opcode  out  5  ALU operation select; valid only while Zin=1, otherwise 5'b00000.
REQ-008 Read, Write, IncPC  out  1 each  memory-read, memory-write and PC-increment strobes.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file field selects and register-file bus enables.
REQ-010 HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin  out  1 each  register load enables.
REQ-011 HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout, Inportout, Outportout, Cout  out  1 each  bus drive enables.

Function
REQ-012 Outputs SHALL be a pure (Moore) decode of the present state and IR, held for exactly one clock per state; any output not listed for a state is 0.
REQ-013 States: RST, T0–T7, HALT; one state per clock.
REQ-014 RST SHALL go to T0, or to HALT if Stop=1.
REQ-015 T0 (fetch): PCout, MARin, IncPC, Zin, opcode=00011.
REQ-016 T1 (fetch): Zlowout, PCin, Read, MDRin.
REQ-017 T2 (fetch): MDRout, IRin; the instruction is decoded from IR in T3 and later.
REQ-018 Opcodes: ld 00000, addi 01100, st 00010, add 00011, sub 00100, and 00101, or 00110, jr 10100, mfhi 11000, mflo 11001, nop 11010, halt 11011.
REQ-019 mfhi: T3 = Gra, Rin, HIout.
REQ-020 mflo: T3 = Gra, Rin, LOout.
REQ-021 jr: T3 = Gra, Rout, PCin.
REQ-022 nop and any undefined opcode: T3 asserts nothing.
REQ-023 add/sub/and/or:
- T3 = Grb, Rout, Yin.
- T4 = Grc, Rout, Zin, opcode=IR[31:27].
- T5 = Zlowout, Gra, Rin.
REQ-024 addi: T3 = Grb, Rout, Yin; T4 = Cout, Zin, opcode=00011; T5 as REQ-023.
REQ-025 ld/st shared steps: T3 = Grb, BAout, Yin; T4 = Cout, Zin, opcode=00011; T5 = Zlowout, MARin.
REQ-026 ld: T6 = Read, MDRin; T7 = MDRout, Gra, Rin.
REQ-027 st: T6 = Gra, Rout, MDRin (Read=0); T7 = Write.
REQ-028 Each instruction's last state SHALL go to T0, or to HALT if Stop=1 at that edge.
REQ-029 halt: T3 asserts nothing, then goes to HALT.
REQ-030 HALT SHALL assert no control outputs, set Run=0, and persist until clear is asserted.
REQ-031 Stop asserted during T0–T6 SHALL NOT truncate the current instruction.
REQ-032 Read and Write SHALL never be high in the same cycle.

Reset
REQ-033 While clear=0, the state SHALL be RST, every control output 0, opcode 5'b00000 and Run 0, regardless of Clock.
REQ-034 Reset asserted mid-instruction SHALL abandon that instruction immediately, with no partial strobes afterwards.
REQ-035 After clear rises, the first rising edge SHALL enter T0 (or HALT if Stop=1).

Structure
REQ-036 Shared package cpu_pkg SHALL hold the opcode constants and the state enumeration (4-bit encoding).
REQ-037 No sub-module SHALL be used; the state register and the output decode live in control_unit.

Verification
REQ-038 The bench SHALL cover reset: clear=0 during T4 of an add -> all outputs 0 at once, Run=0; clear=1 -> T0 signals on the 1st edge.
REQ-039 The bench SHALL cover mfhi: IR=0xC0800000 (R1) -> T0/T1/T2 fetch signals, then T3 = Gra, Rin, HIout, then T0; 4 cycles total.
REQ-040 The bench SHALL cover add: IR=0x18918000 (R1=R2+R3) -> T4 with opcode=00011, Grc, Rout, Zin; T5 = Zlowout, Gra, Rin; 6 cycles total.
REQ-041 The bench SHALL cover ld: IR=0x01000055 -> T5 MARin, T6 Read+MDRin, T7 MDRout+Gra+Rin; 8 cycles total.
REQ-042 The bench SHALL cover st: IR=0x11800020 -> T6 Gra+Rout+MDRin with Read=0, T7 Write=1; Read and Write never both high.
REQ-043 The bench SHALL cover halt and Stop: IR=0xD8000000 -> Run=0 after T3 and no strobes for 20 cycles; Stop=1 during an add's T4 -> T5 completes, then HALT.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, control-unit state encoding,
// the control-strobe bundle and small opcode classification helpers.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic read, write, inc_pc;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in;
        logic inport_in, outport_in, con_in;
        logic hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out, mar_out;
        logic mdr_out, inport_out, outport_out, c_out;
    } ctrl_t;

    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Instructions that run the Y/Z datapath through T4 and T5.
    function automatic logic uses_yz(input logic [4:0] op);
        return is_alu(op) || (op == OP_ADDI) || is_mem(op);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hard-wired CPU control unit: fetch/execute sequencer with a Moore decode
// of the present state and the instruction register.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  opcode,
    output logic        Read, Write, IncPC,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
    output logic        Inportin, Outportin, CONin,
    output logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout,
    output logic        MDRout, Inportout, Outportout, Cout
);

    state_t      state_reg;
    state_t      done_target;
    ctrl_t       ctrl;
    logic [4:0]  alu_op;
    logic [4:0]  op_ir;
    logic        unused_ir_bits;

    assign op_ir = IR[31:27];
    // Operand fields are consumed by the register file, not by this block.
    assign unused_ir_bits = ^IR[26:0];

    // Stop only takes effect at an instruction's final state.
    assign done_target = Stop ? S_HALT : S_T0;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_reg <= S_RST;
        end else begin
            case (state_reg)
                S_RST:  state_reg <= done_target;
                S_T0:   state_reg <= S_T1;
                S_T1:   state_reg <= S_T2;
                S_T2:   state_reg <= S_T3;
                S_T3: begin
                    if (op_ir == OP_HALT)
                        state_reg <= S_HALT;
                    else if (uses_yz(op_ir))
                        state_reg <= S_T4;
                    else
                        state_reg <= done_target;
                end
                S_T4:   state_reg <= S_T5;
                S_T5:   state_reg <= is_mem(op_ir) ? S_T6 : done_target;
                S_T6:   state_reg <= S_T7;
                S_T7:   state_reg <= done_target;
                S_HALT: state_reg <= S_HALT;
                default: state_reg <= S_RST;
            endcase
        end
    end

    always_comb begin
        ctrl   = '0;
        alu_op = 5'b00000;
        case (state_reg)
            S_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
                alu_op = OP_ADD;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            S_T3: begin
                if (op_ir == OP_MFHI) begin
                    ctrl.gra = 1'b1; ctrl.r_in = 1'b1; ctrl.hi_out = 1'b1;
                end else if (op_ir == OP_MFLO) begin
                    ctrl.gra = 1'b1; ctrl.r_in = 1'b1; ctrl.lo_out = 1'b1;
                end else if (op_ir == OP_JR) begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
                end else if (is_alu(op_ir) || op_ir == OP_ADDI) begin
                    ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                end else if (is_mem(op_ir)) begin
                    ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu(op_ir)) begin
                    ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                    alu_op = op_ir;
                end else if (uses_yz(op_ir)) begin
                    ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
                    alu_op = OP_ADD;
                end
            end
            S_T5: begin
                if (is_mem(op_ir)) begin
                    ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                end else if (uses_yz(op_ir)) begin
                    ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end
            end
            S_T6: begin
                if (op_ir == OP_LD) begin
                    ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                end else if (op_ir == OP_ST) begin
                    ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                end
            end
            S_T7: begin
                if (op_ir == OP_LD) begin
                    ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (op_ir == OP_ST) begin
                    ctrl.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Run    = (state_reg != S_RST) && (state_reg != S_HALT);
    assign opcode = ctrl.z_in ? alu_op : 5'b00000;

    assign Read       = ctrl.read;
    assign Write      = ctrl.write;
    assign IncPC      = ctrl.inc_pc;
    assign Gra        = ctrl.gra;
    assign Grb        = ctrl.grb;
    assign Grc        = ctrl.grc;
    assign Rin        = ctrl.r_in;
    assign Rout       = ctrl.r_out;
    assign BAout      = ctrl.ba_out;
    assign HIin       = ctrl.hi_in;
    assign LOin       = ctrl.lo_in;
    assign Yin        = ctrl.y_in;
    assign Zin        = ctrl.z_in;
    assign PCin       = ctrl.pc_in;
    assign IRin       = ctrl.ir_in;
    assign MARin      = ctrl.mar_in;
    assign MDRin      = ctrl.mdr_in;
    assign Inportin   = ctrl.inport_in;
    assign Outportin  = ctrl.outport_in;
    assign CONin      = ctrl.con_in;
    assign HIout      = ctrl.hi_out;
    assign LOout      = ctrl.lo_out;
    assign Yout       = ctrl.y_out;
    assign Zhighout   = ctrl.zhigh_out;
    assign Zlowout    = ctrl.zlow_out;
    assign PCout      = ctrl.pc_out;
    assign MARout     = ctrl.mar_out;
    assign MDRout     = ctrl.mdr_out;
    assign Inportout  = ctrl.inport_out;
    assign Outportout = ctrl.outport_out;
    assign Cout       = ctrl.c_out;

endmodule
